// File: rtl/fifo_chk_pkg.sv
// Shared definitions for the FIFO in-line checker: compare field indices and
// the per-field result vector type.
package fifo_chk_pkg;

    localparam int NUM_CHK_FIELDS = 8;

    localparam int CHK_DOUT   = 0;
    localparam int CHK_ACK    = 1;
    localparam int CHK_OVF    = 2;
    localparam int CHK_UDF    = 3;
    localparam int CHK_FULL   = 4;
    localparam int CHK_EMPTY  = 5;
    localparam int CHK_AFULL  = 6;
    localparam int CHK_AEMPTY = 7;

    typedef logic [NUM_CHK_FIELDS-1:0] chk_vec_t;

endpackage

// File: rtl/fifo_ref_model.sv
// Golden model of the synchronous FIFO: shadow memory, pointers, occupancy and
// the expected registered outputs and combinational flags.
module fifo_ref_model #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] dout_exp,
    output logic                  ack_exp,
    output logic                  ovf_exp,
    output logic                  udf_exp,
    output logic                  full_exp,
    output logic                  empty_exp,
    output logic                  afull_exp,
    output logic                  aempty_exp
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full_exp   = (count == CNT_W'(DEPTH));
    assign empty_exp  = (count == '0);
    assign afull_exp  = (count == CNT_W'(AF_LEVEL));
    assign aempty_exp = (count == CNT_W'(AE_LEVEL));

    // Full blocks the write and empty blocks the read, so a simultaneous
    // request at either extreme degrades to a single accepted operation.
    assign wr_acc = wr_en && !full_exp;
    assign rd_acc = rd_en && !empty_exp;

    // NOTE: the shadow memory has no reset; valid data is defined only by the
    // pointers, and a reset port on the array would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dout_exp <= '0;
            ack_exp  <= 1'b0;
            ovf_exp  <= 1'b0;
            udf_exp  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                dout_exp <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            ack_exp <= wr_acc;
            ovf_exp <= wr_en && full_exp;
            udf_exp <= rd_en && empty_exp;
        end
    end

endmodule

// File: rtl/fifo_checker.sv
// In-line FIFO checker: compares the DUT outputs against fifo_ref_model every
// cycle and keeps saturating counters, sticky field errors and a first-error capture.
module fifo_checker
    import fifo_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  check_en,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  wr_ack,
    input  logic                  overflow,
    input  logic                  underflow,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  almostfull,
    input  logic                  almostempty,
    output logic                  mismatch,
    output chk_vec_t              err_vec,
    output chk_vec_t              first_err_vec,
    output logic [CNT_WIDTH-1:0]  first_err_cycle,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [CNT_WIDTH-1:0]  correct_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] dout_exp;
    logic                  ack_exp, ovf_exp, udf_exp;
    logic                  full_exp, empty_exp, afull_exp, aempty_exp;
    chk_vec_t              diff;
    logic                  any_diff;
    logic                  first_seen;
    logic [CNT_WIDTH-1:0]  cycle_cnt;

    fifo_ref_model #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) u_model (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_in    (data_in),
        .dout_exp   (dout_exp),
        .ack_exp    (ack_exp),
        .ovf_exp    (ovf_exp),
        .udf_exp    (udf_exp),
        .full_exp   (full_exp),
        .empty_exp  (empty_exp),
        .afull_exp  (afull_exp),
        .aempty_exp (aempty_exp)
    );

    // NOTE: default every bit first so no path through this block can infer a latch.
    always_comb begin
        diff             = '0;
        diff[CHK_DOUT]   = (data_out != dout_exp);
        diff[CHK_ACK]    = (wr_ack != ack_exp);
        diff[CHK_OVF]    = (overflow != ovf_exp);
        diff[CHK_UDF]    = (underflow != udf_exp);
        diff[CHK_FULL]   = (full != full_exp);
        diff[CHK_EMPTY]  = (empty != empty_exp);
        diff[CHK_AFULL]  = (almostfull != afull_exp);
        diff[CHK_AEMPTY] = (almostempty != aempty_exp);
    end

    assign any_diff = |diff;

    // The stamp runs regardless of check_en so captured cycles stay absolute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt       <= '0;
            mismatch        <= 1'b0;
            err_vec         <= '0;
            first_err_vec   <= '0;
            first_err_cycle <= '0;
            first_seen      <= 1'b0;
            error_count     <= '0;
            correct_count   <= '0;
        end else begin
            if (cycle_cnt != CNT_MAX) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end
            mismatch <= check_en && any_diff;
            if (check_en) begin
                if (any_diff) begin
                    if (error_count != CNT_MAX) begin
                        error_count <= error_count + CNT_ONE;
                    end
                    err_vec <= err_vec | diff;
                    if (!first_seen) begin
                        first_seen      <= 1'b1;
                        first_err_vec   <= diff;
                        first_err_cycle <= cycle_cnt;
                    end
                end else if (correct_count != CNT_MAX) begin
                    correct_count <= correct_count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_checker.sv
// Bench for fifo_checker: emulates a FIFO DUT with a queue, injects field
// faults, and predicts the checker results from the injected fault masks.
module tb_fifo_checker;
    import fifo_chk_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int CWS   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic check_en = 1'b0;
    logic wr_en = 1'b0;
    logic rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic wr_ack, overflow, underflow, full, empty, almostfull, almostempty;

    logic          mismatch, mismatch_s;
    chk_vec_t      err_vec, first_err_vec, err_vec_s, first_err_vec_s;
    logic [CW-1:0] first_err_cycle, error_count, correct_count;
    logic [CWS-1:0] first_err_cycle_s, error_count_s, correct_count_s;

    // Emulated FIFO DUT state and the fault applied to what it presents.
    logic [DW-1:0] q[$];
    int            occ = 0;
    logic [DW-1:0] true_dout = '0;
    logic          true_ack = 1'b0, true_ovf = 1'b0, true_udf = 1'b0;
    chk_vec_t      cmask = '0;
    logic [DW-1:0] dxor = '0;

    // Expected checker results, kept as plain unbounded integers.
    int       m_err = 0, m_ok = 0, m_stamp = 0, m_first_cycle = 0;
    bit       m_first_seen = 0, m_mismatch = 0;
    chk_vec_t m_err_vec = '0, m_first_vec = '0;

    int  n_checks = 0, n_errors = 0;
    bit  cmp_on = 0;

    always #5 clk = ~clk;

    assign data_out    = true_dout ^ (cmask[CHK_DOUT] ? dxor : '0);
    assign wr_ack      = true_ack ^ cmask[CHK_ACK];
    assign overflow    = true_ovf ^ cmask[CHK_OVF];
    assign underflow   = true_udf ^ cmask[CHK_UDF];
    assign full        = (occ == DEPTH) ^ cmask[CHK_FULL];
    assign empty       = (occ == 0) ^ cmask[CHK_EMPTY];
    assign almostfull  = (occ == DEPTH - 1) ^ cmask[CHK_AFULL];
    assign almostempty = (occ == 1) ^ cmask[CHK_AEMPTY];

    fifo_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .check_en(check_en), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
        .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
        .almostempty(almostempty), .mismatch(mismatch), .err_vec(err_vec),
        .first_err_vec(first_err_vec), .first_err_cycle(first_err_cycle),
        .error_count(error_count), .correct_count(correct_count)
    );

    // Narrow-counter instance on the same signals exercises saturation.
    fifo_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CWS)) dut_s (
        .clk(clk), .rst_n(rst_n), .check_en(check_en), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
        .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
        .almostempty(almostempty), .mismatch(mismatch_s), .err_vec(err_vec_s),
        .first_err_vec(first_err_vec_s), .first_err_cycle(first_err_cycle_s),
        .error_count(error_count_s), .correct_count(correct_count_s)
    );

    function automatic int sat(input int x, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (x > lim) ? lim : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("mismatch",        32'(mismatch),        32'(m_mismatch));
            check("err_vec",         32'(err_vec),         32'(m_err_vec));
            check("error_count",     32'(error_count),     32'(sat(m_err, CW)));
            check("correct_count",   32'(correct_count),   32'(sat(m_ok, CW)));
            check("first_err_vec",   32'(first_err_vec),   32'(m_first_vec));
            check("first_err_cycle", 32'(first_err_cycle), 32'(sat(m_first_cycle, CW)));
            check("s_mismatch",      32'(mismatch_s),      32'(m_mismatch));
            check("s_err_vec",       32'(err_vec_s),       32'(m_err_vec));
            check("s_error_count",   32'(error_count_s),   32'(sat(m_err, CWS)));
            check("s_correct_count", 32'(correct_count_s), 32'(sat(m_ok, CWS)));
            check("s_first_cycle",   32'(first_err_cycle_s), 32'(sat(m_first_cycle, CWS)));
        end
    end

    // One clock edge: present stimulus and fault, then advance both models.
    task automatic step(input logic we, input logic re, input logic [DW-1:0] d,
                        input logic ce, input chk_vec_t m);
        int  pre;
        bit  wa, ra;
        wr_en    = we;
        rd_en    = re;
        data_in  = d;
        check_en = ce;
        cmask    = m;
        dxor     = m[CHK_DOUT] ? DW'($urandom_range(1, 65535)) : '0;
        @(posedge clk);
        #1;
        if (ce) begin
            if (m != '0) begin
                m_err++;
                m_err_vec |= m;
                if (!m_first_seen) begin
                    m_first_seen  = 1;
                    m_first_vec   = m;
                    m_first_cycle = m_stamp;
                end
            end else begin
                m_ok++;
            end
        end
        m_mismatch = ce && (m != '0);
        m_stamp++;
        pre = occ;
        wa = we && (pre < DEPTH);
        ra = re && (pre > 0);
        true_ack = wa;
        true_ovf = we && (pre == DEPTH);
        true_udf = re && (pre == 0);
        if (ra) true_dout = q.pop_front();
        if (wa) q.push_back(d);
        occ   = q.size();
        cmask = '0;
        dxor  = '0;
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        check_en = 1'b0;
        cmask    = '0;
        dxor     = '0;
        q.delete();
        occ = 0;
        true_dout = '0;
        true_ack = 1'b0;
        true_ovf = 1'b0;
        true_udf = 1'b0;
        m_err = 0; m_ok = 0; m_stamp = 0; m_first_cycle = 0;
        m_first_seen = 0; m_mismatch = 0; m_err_vec = '0; m_first_vec = '0;
        #2;
        check("rst_mismatch",    32'(mismatch),        32'd0);
        check("rst_err_vec",     32'(err_vec),         32'd0);
        check("rst_error_count", 32'(error_count),     32'd0);
        check("rst_correct",     32'(correct_count),   32'd0);
        check("rst_first_vec",   32'(first_err_vec),   32'd0);
        check("rst_first_cycle", 32'(first_err_cycle), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic     we_r, re_r, ce_r;
        chk_vec_t m_r;
        int       phase;

        #1;
        reset_dut();
        cmp_on = 1;

        // Fill then drain with a known pattern.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(16'h1000 + i), 1'b1, '0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b1, '0);
        check("tc1_correct", 32'(correct_count), 32'd16);
        check("tc1_errors",  32'(error_count),   32'd0);

        // Full FIFO with simultaneous write and read.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(16'h2000 + i), 1'b1, '0);
        step(1'b1, 1'b1, 16'hDEAD, 1'b1, '0);
        step(1'b0, 1'b0, '0, 1'b1, '0);
        check("tc2_mismatch", 32'(mismatch),      32'd0);
        check("tc2_correct",  32'(correct_count), 32'd26);

        // Drain, read on empty, then present underflow stuck at 0.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0, 1'b1, '0);
        step(1'b0, 1'b1, '0, 1'b1, '0);
        step(1'b0, 1'b0, '0, 1'b1, chk_vec_t'(8'h08));
        check("tc3_mismatch",    32'(mismatch),        32'd1);
        check("tc3_err_vec",     32'(err_vec),         32'h08);
        check("tc3_error_count", 32'(error_count),     32'd1);
        check("tc3_correct",     32'(correct_count),   32'd34);
        check("tc3_first_cycle", 32'(first_err_cycle), 32'd34);

        // Data corruption on the third read's output, compared at stamp 20.
        reset_dut();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(16'h3000 + i), 1'b1, '0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b1, '0);
        step(1'b0, 1'b1, '0, 1'b1, chk_vec_t'(8'h01));
        step(1'b0, 1'b1, '0, 1'b1, '0);
        step(1'b0, 1'b0, '0, 1'b1, '0);
        check("tc4_first_vec",   32'(first_err_vec),   32'h01);
        check("tc4_first_cycle", 32'(first_err_cycle), 32'd20);
        check("tc4_err_vec",     32'(err_vec),         32'h01);
        check("tc4_error_count", 32'(error_count),     32'd1);

        // Reset mid-burst at occupancy 5, then a clean restart.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom), 1'b1, '0);
        reset_dut();
        step(1'b0, 1'b0, '0, 1'b1, '0);
        check("tc5_correct", 32'(correct_count), 32'd1);
        check("tc5_errors",  32'(error_count),   32'd0);

        // One real failure, then ten faulty cycles with checking disabled.
        step(1'b0, 1'b0, '0, 1'b1, chk_vec_t'(8'h10));
        for (int i = 0; i < 10; i++)
            step(1'(i % 2), 1'(i % 3 == 0), DW'($urandom), 1'b0, chk_vec_t'($urandom_range(1, 255)));
        check("tc6_mismatch",    32'(mismatch),        32'd0);
        check("tc6_error_count", 32'(error_count),     32'd1);
        check("tc6_err_vec",     32'(err_vec),         32'h10);
        check("tc6_first_vec",   32'(first_err_vec),   32'h10);
        check("tc6_first_cycle", 32'(first_err_cycle), 32'd1);

        // Randomised traffic: fill-biased, drain-biased and balanced phases.
        for (int i = 0; i < 600; i++) begin
            phase = (i / 40) % 3;
            case (phase)
                0:       begin we_r = ($urandom_range(0, 3) != 0); re_r = ($urandom_range(0, 3) == 0); end
                1:       begin we_r = ($urandom_range(0, 3) == 0); re_r = ($urandom_range(0, 3) != 0); end
                default: begin we_r = 1'($urandom_range(0, 1));   re_r = 1'($urandom_range(0, 1)); end
            endcase
            ce_r = ($urandom_range(0, 9) != 0);
            m_r  = ($urandom_range(0, 9) == 0) ? chk_vec_t'($urandom_range(1, 255)) : '0;
            step(we_r, re_r, DW'($urandom), ce_r, m_r);
        end

        @(negedge clk);
        cmp_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_checker.md
# fifo_checker

Parametrised, synthesizable in-line checker for the synchronous FIFO. It sits beside the DUT on the same `fifo` interface signals and runs an internal golden model of width DATA_WIDTH and depth DEPTH. Each cycle it compares every DUT output against that model and keeps saturating pass/fail counters, sticky per-field error bits and a first-error capture. It is a generalised hardware successor of the bench monitor/scoreboard pair, and it can also be used in emulation.

## Interface
- DATA_WIDTH, 16, data word width
- DEPTH, 8, FIFO depth; power of two, ≥4
- AF_LEVEL, DEPTH-1, occupancy at which almostfull is expected
- AE_LEVEL, 1, occupancy at which almostempty is expected
- CNT_WIDTH, 16, width of the counters and the cycle stamp
- clk  in  1  single clock; all sampling on rising edge
- rst_n  in  1  asynchronous, active-low reset; shared with the DUT
- check_en  in  1  compare and count enable; the model always tracks
- wr_en, rd_en  in  1 each  DUT stimulus
- data_in  in  DATA_WIDTH  DUT write data
- data_out  in  DATA_WIDTH  DUT read data (registered in DUT)
- wr_ack, overflow, underflow  in  1 each  DUT registered status
- full, empty, almostfull, almostempty  in  1 each  DUT combinational flags
- mismatch  out  1  registered pulse: a compare failed at the last edge
- err_vec  out  8  sticky per-field error bits
- first_err_vec  out  8  field bits of the first failing compare
- first_err_cycle  out  CNT_WIDTH  cycle stamp of the first failing compare
- error_count, correct_count  out  CNT_WIDTH each  saturating compare counters

## Operation
- Model state:
  - shadow memory of DEPTH words
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping naturally
  - count, log2(DEPTH)+1 bits
  - expected registered outputs: dout_exp, ack_exp, ovf_exp, udf_exp
- Expected flags, derived from count before the edge:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almostfull = (count==AF_LEVEL)
  - almostempty = (count==AE_LEVEL)
- Model update at each rising edge:
  - A write is accepted when wr_en && !full_exp.
  - A read is accepted when rd_en && !empty_exp.
  - Simultaneous wr_en and rd_en:
    - when full: read only, and overflow is expected
    - when empty: write only, and underflow is expected
    - otherwise: both are accepted and count is unchanged
  - ack_exp ← write accepted
  - ovf_exp ← wr_en && full_exp
  - udf_exp ← rd_en && empty_exp
  - dout_exp ← mem[rd_ptr] on an accepted read, else it holds
- Compare at each rising edge with check_en=1:
  - Field order, bit0→7: data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty.
  - Registered fields are checked against the expectations from the previous edge. Flags are checked against the pre-update count.
  - If any field differs: error_count++, mismatch=1, err_vec |= diff.
  - If no field differs: correct_count++.
  - On the first failure after reset: capture first_err_vec and first_err_cycle.
- Counter and stamp rules:
  - Both counters saturate at 2^CNT_WIDTH−1.
  - The cycle stamp counts every edge out of reset and also saturates.
- With check_en=0: counters, sticky bits and capture are frozen, mismatch=0, and the model keeps tracking.

## Timing
- Reset (async, any time, including mid-burst) clears:
  - pointers, count, all expectations and all outputs
  - memory contents are not cleared
- First compare: the first rising edge with rst_n=1. At that edge the expectation is empty=1, almostempty=(AE_LEVEL==0), and all registered fields 0.
- mismatch, err_vec and the counters update at the compare edge and are visible after it. Latency is one cycle from DUT output to result.
- Pointer wrap DEPTH−1→0 is transparent; count never exceeds DEPTH and never underflows.
- No combinational path from the inputs to any output.

## Structure
- Shared package fifo_chk_pkg holds:
  - field index constants (CHK_DOUT … CHK_AEMPTY)
  - NUM_CHK_FIELDS=8
  - typedef chk_vec_t (logic [NUM_CHK_FIELDS-1:0])
- Sub-module fifo_ref_model contains the memory, pointers, count and expectations, and exports the expected values.
- The top level contains the compare, sticky, capture and counter logic.

## Test plan
All scenarios use DATA_WIDTH=16, DEPTH=8 and a correct DUT unless stated.
- Write 8 words 0x1000..0x1007, then read 8. Required: correct_count=16 and error_count=0; full expected after the 8th write; data_out sequence matches.
- Full FIFO, then wr_en=1 and rd_en=1 together. Required: model accepts the read only; ovf_exp=1 and ack_exp=0; count goes 8→7; no mismatch.
- Empty FIFO, then rd_en=1. Required: udf_exp=1 the next cycle. A DUT with underflow stuck at 0 gives mismatch=1, err_vec=8'b0000_1000 and error_count=1.
- Corrupt DUT data_out bit 3 on the 3rd read, stamp 20. Required: first_err_vec=8'h01 and first_err_cycle=20; err_vec stays 8'h01 after further clean reads.
- Assert rst_n=0 mid-burst at count=5, then release. Required: all outputs 0 and the model empty; next compare expects empty=1; counters restart from 0.
- Hold check_en=0 across 10 mismatching cycles. Required: counters, err_vec and first_err_* are unchanged and mismatch=0.
